// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - requester and CDB broadcast bundle for cdb_arbiter
//
// Purpose: groups the functional-unit request bus, the flush input and the
// registered CDB broadcast into one interface.
// Ports (signals):
//   flush      - branch-mispredict squash
//   req_valid  - per-requester result valid      (NUM_REQ)
//   req_tag    - per-requester ROB tag           (NUM_REQ x TAG_W)
//   req_value  - per-requester result value      (NUM_REQ x DATA_W)
//   req_dest   - per-requester dest register     (NUM_REQ x 5)
//   req_ready  - one-hot grant                   (NUM_REQ)
//   cdb_valid / cdb_tag / cdb_value / cdb_dest - registered broadcast
//   rr_ptr     - round-robin start index (debug)
// Modports: slave = arbiter side, master = requester/consumer side.

`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(`ROB_SIZE),
  parameter int DATA_W  = `XLEN
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                             flush;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]    req_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_value;
  logic [NUM_REQ-1:0][4:0]          req_dest;
  logic [NUM_REQ-1:0]               req_ready;
  logic                             cdb_valid;
  logic [TAG_W-1:0]                 cdb_tag;
  logic [DATA_W-1:0]                cdb_value;
  logic [4:0]                       cdb_dest;
  logic [PTR_W-1:0]                 rr_ptr;

  modport slave (
    input  flush, req_valid, req_tag, req_value, req_dest,
    output req_ready, cdb_valid, cdb_tag, cdb_value, cdb_dest, rr_ptr
  );

  modport master (
    output flush, req_valid, req_tag, req_value, req_dest,
    input  req_ready, cdb_valid, cdb_tag, cdb_value, cdb_dest, rr_ptr
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common-data-bus arbiter with registered broadcast
//
// Purpose: picks one of NUM_REQ functional-unit results per cycle and
// broadcasts it on the CDB one cycle later.
// Ports:
//   clock - single clock, all state on posedge
//   reset - asynchronous active-low reset
//   bus   - cdb_arbiter_if.slave (requests, flush, grant, CDB payload, rr_ptr)
// Optional feature macro: CDB_BRANCH_PRIO_EN - index 0 (branch unit) always
// wins when valid and does not advance rr_ptr.

`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif
`ifndef XLEN
`define XLEN 32
`endif

module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = $clog2(`ROB_SIZE),
  parameter int DATA_W  = `XLEN
) (
  input  logic         clock,
  input  logic         reset,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q,   cdb_tag_d;
  logic [DATA_W-1:0]  cdb_value_q, cdb_value_d;
  logic [4:0]         cdb_dest_q,  cdb_dest_d;
  logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;

  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               prio_hit;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand;

  always_comb begin
    grant     = '0;
    found     = 1'b0;
    prio_hit  = 1'b0;
    grant_idx = '0;
    cand      = '0;

    // Reset gating keeps req_ready low while reset is held, since the
    // grant is purely combinational.
    if (reset && !bus.flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!found && bus.req_valid[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
`ifdef CDB_BRANCH_PRIO_EN
      if (bus.req_valid[0]) begin
        found     = 1'b1;
        prio_hit  = 1'b1;
        grant_idx = '0;
      end
`endif
    end

    if (found) grant[grant_idx] = 1'b1;

    cdb_valid_d = found;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_dest_d  = cdb_dest_q;
    if (found) begin
      cdb_tag_d   = bus.req_tag[grant_idx];
      cdb_value_d = bus.req_value[grant_idx];
      cdb_dest_d  = bus.req_dest[grant_idx];
    end

    // A priority grant to the branch unit leaves the rotation untouched so
    // the other units keep their place in line.
    rr_ptr_d = rr_ptr_q;
    if (bus.flush) begin
      rr_ptr_d = '0;
    end else if (found && !prio_hit) begin
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_dest_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_dest_q  <= cdb_dest_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_value = cdb_value_q;
  assign bus.cdb_dest  = cdb_dest_q;
  assign bus.rr_ptr    = rr_ptr_q;
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of functional-unit requesters sharing the CDB.
REQ-002 Parameter TAG_W, default $clog2(`ROB_SIZE), ROB tag width.
REQ-003 Parameter DATA_W, default `XLEN, result value width.
REQ-004 clock  input  1  single clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 flush  input  1  branch-mispredict squash (take_branch).
REQ-007 req_valid  input  NUM_REQ  per-requester result valid.
REQ-008 req_tag  input  NUM_REQ x TAG_W  per-requester ROB tag.
REQ-009 req_value  input  NUM_REQ x DATA_W  per-requester result value.
REQ-010 req_dest  input  NUM_REQ x 5  per-requester destination register index.
REQ-011 req_ready  output  NUM_REQ  one-hot grant; transfer when req_valid[i] and req_ready[i].
REQ-012 cdb_valid  output  1  registered CDB broadcast valid.
REQ-013 cdb_tag / cdb_value / cdb_dest  output  TAG_W / DATA_W / 5  registered CDB payload.
REQ-014 rr_ptr  output  $clog2(NUM_REQ)  current round-robin start index (debug).

Function
REQ-015 req_ready SHALL be combinational from req_valid, rr_ptr and flush, at most one bit set.
REQ-016 Arbitration SHALL search indices rr_ptr, rr_ptr+1, ... modulo NUM_REQ; the first valid index is granted.
REQ-017 No bit of req_ready SHALL be set when no req_valid bit is set, or when flush=1.
REQ-018 A grant to index g in cycle N SHALL drive cdb_valid=1 and g's tag/value/dest on cycle N+1 (latency 1).
REQ-019 With no grant in cycle N, cdb_valid SHALL be 0 in N+1; payload fields hold their previous values.
REQ-020 After a grant to g, rr_ptr SHALL become (g+1) mod NUM_REQ; wrap from NUM_REQ-1 to 0.
REQ-021 Without a grant, rr_ptr SHALL hold.
REQ-022 Ungranted requesters SHALL keep req_valid and payload stable until granted; the arbiter stores no per-requester state.
REQ-023 flush=1 SHALL force cdb_valid=0 on the next cycle, reset rr_ptr to 0, and grant nobody that cycle.
REQ-024 flush SHALL take precedence over any simultaneous request.
REQ-025 A requester with dest index 0 SHALL still be arbitrated and broadcast unchanged.
REQ-026 Any requester SHALL be granted within NUM_REQ cycles of asserting valid, barring flush or REQ-030.

Reset
REQ-027 While reset=0: cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_dest=0, rr_ptr=0, req_ready=0.
REQ-028 Assertion mid-operation SHALL clear state immediately (asynchronous), discarding any pending broadcast.
REQ-029 The first grant SHALL be possible in the first posedge after reset returns to 1.

Configuration
REQ-030 Macro CDB_BRANCH_PRIO_EN defined: index 0 (branch unit) wins whenever req_valid[0]=1, and rr_ptr holds on that grant; other indices use round-robin as in REQ-016/020.
REQ-031 Macro CDB_BRANCH_PRIO_EN undefined: pure round-robin over all indices including 0; REQ-026 holds unconditionally.

Verification
REQ-032 Reset, then req_valid=4'b0100, tag=5, value=0x1234 -> req_ready=4'b0100 same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_value=0x1234; rr_ptr=3.
REQ-033 req_valid=4'b1111 held 4 cycles from rr_ptr=0 -> grants 0,1,2,3 in order; rr_ptr ends at 0 (wrap).
REQ-034 rr_ptr=3, req_valid=4'b1001 -> grant index 3, then index 0.
REQ-035 req_valid=4'b0011 with flush=1 -> req_ready=0; next cycle cdb_valid=0, rr_ptr=0.
REQ-036 Reset driven 0 between grant and broadcast edge -> cdb_valid=0 immediately, no broadcast after release.
REQ-037 CDB_BRANCH_PRIO_EN defined, req_valid[0] held 1 with 4'b0110 also set -> index 0 granted every cycle, rr_ptr unchanged; undefined -> grants rotate 0,1,2,0.
